// File: rtl/encode_imm_inst.sv
// Purpose: RV32I OP-IMM encoder. Builds {imm12, rs1, funct3, rd, 7'b0010011}
//          from (alu_control, rs1, rd, imm), tags each word with a sequential
//          byte address and queues it in a 2-entry output FIFO.
// Latency: 1 cycle from the accepting edge to the FIFO head when the FIFO is empty.
// Backpressure: in_ready = !restart && count < 2; a pop frees space only from the next cycle.
// Ports:   clk/rst (sync, active-high), restart (sync flush), in_* request
//          (valid/ready), out_* FIFO head (valid/ready), err_illegal pulse,
//          emit_count (saturating count of accepted legal requests).
// Option:  define ENC_SHAMT_CHECK_EN to reject shifts whose in_imm[11:5] != 0.

`ifndef ADDI
`define ADDI  5'h00
`define SLLI  5'h01
`define SLTI  5'h02
`define SLTIU 5'h03
`define XORI  5'h04
`define SRLI  5'h05
`define SRAI  5'h06
`define ORI   5'h07
`define ANDI  5'h08
`endif

module encode_imm_inst #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_alu_control,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rd,
    input  logic [11:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [15:0]       emit_count
);

    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    // State
    logic [31:0]       instr_mem_q [2];
    logic [31:0]       instr_mem_d [2];
    logic [ADDR_W-1:0] addr_mem_q  [2];
    logic [ADDR_W-1:0] addr_mem_d  [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q,  count_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [15:0]       emit_q,   emit_d;
    logic              err_q,    err_d;

    // Encoder
    logic        legal;
    logic [2:0]  funct3;
    logic [11:0] imm12;
    logic [31:0] instr_enc;

    always_comb begin
        legal  = 1'b1;
        funct3 = 3'd0;
        imm12  = in_imm;
        case (in_alu_control)
            `ADDI:  funct3 = 3'd0;
            `SLTI:  funct3 = 3'd2;
            `SLTIU: funct3 = 3'd3;
            `XORI:  funct3 = 3'd4;
            `ORI:   funct3 = 3'd6;
            `ANDI:  funct3 = 3'd7;
            `SLLI: begin
                funct3 = 3'd1;
                imm12  = {7'h00, in_imm[4:0]};
            end
            `SRLI: begin
                funct3 = 3'd5;
                imm12  = {7'h00, in_imm[4:0]};
            end
            `SRAI: begin
                funct3 = 3'd5;
                imm12  = {7'h20, in_imm[4:0]};
            end
            default: legal = 1'b0;
        endcase
`ifdef ENC_SHAMT_CHECK_EN
        if ((in_alu_control == `SLLI || in_alu_control == `SRLI ||
             in_alu_control == `SRAI) && (in_imm[11:5] != 7'h00)) begin
            legal = 1'b0;
        end
`endif
    end

    assign instr_enc = {imm12, in_rs1, funct3, in_rd, OPCODE_OP_IMM};

    // Handshakes; restart blocks both sides
    logic accept, push, pop;

    assign in_ready  = !restart && (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready && !restart;

    always_comb begin
        instr_mem_d = instr_mem_q;
        addr_mem_d  = addr_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        addr_d      = addr_q;
        emit_d      = emit_q;
        err_d       = accept && !legal;
        if (restart) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
            addr_d   = BASE_ADDR;
            emit_d   = 16'd0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = instr_enc;
                addr_mem_d[wr_ptr_q]  = addr_q;
                wr_ptr_d              = !wr_ptr_q;
                // Natural modulo wrap: the top address rolls over to 0, not BASE_ADDR
                addr_d                = addr_q + ADDR_W'(4);
                if (emit_q != 16'hFFFF) begin
                    emit_d = emit_q + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr_d = !rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_mem_q[0] <= '0;
            instr_mem_q[1] <= '0;
            addr_mem_q[0]  <= '0;
            addr_mem_q[1]  <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            addr_q         <= BASE_ADDR;
            emit_q         <= 16'd0;
            err_q          <= 1'b0;
        end else begin
            instr_mem_q <= instr_mem_d;
            addr_mem_q  <= addr_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            emit_q      <= emit_d;
            err_q       <= err_d;
        end
    end

    // Empty FIFO presents zeros rather than stale entries
    assign out_instr   = out_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
    assign out_addr    = out_valid ? addr_mem_q[rd_ptr_q]  : '0;
    assign err_illegal = err_q;
    assign emit_count  = emit_q;

endmodule

// File: doc/encode_imm_inst.md
# encode_imm_inst

Streaming encoder for RV32I OP-IMM instructions: the inverse of the OP-IMM field decoder. Accepts (alu_control, rs1, rd, imm) requests over a valid/ready handshake, builds the 32-bit instruction word (opcode 7'b0010011), and tags it with a sequential word address. A 2-entry output FIFO feeds the instruction-memory loader or test-program generator. Requests carrying an illegal operation are rejected and flagged.

## Interface
- ADDR_W, 32: width of the emitted address and of the address counter.
- BASE_ADDR, 0: address assigned to the first instruction after reset or restart; must be 4-byte aligned.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- restart  in  1  synchronous flush: empties the FIFO and reloads the address counter.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_alu_control  in  5  operation, using the team's ALU control macros (`ADDI, `SLLI, `SLTI, `SLTIU, `XORI, `SRLI, `SRAI, `ORI, `ANDI).
- in_rs1  in  5  source register.
- in_rd  in  5  destination register.
- in_imm  in  12  immediate; for shifts, only [4:0] is the shamt.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer ready; pop on out_valid && out_ready.
- out_instr  out  32  encoded instruction at the FIFO head.
- out_addr  out  ADDR_W  byte address of out_instr.
- err_illegal  out  1  one-cycle pulse, the cycle after a rejected request.
- emit_count  out  16  legal instructions accepted since reset or restart; saturates at 16'hFFFF.

## Operation
- Encoding is {imm12, rs1, funct3, rd, 7'b0010011}:
  - `ADDI: funct3 0, imm12 = in_imm.
  - `SLTI: funct3 2, imm12 = in_imm.
  - `SLTIU: funct3 3, imm12 = in_imm.
  - `XORI: funct3 4, imm12 = in_imm.
  - `ORI: funct3 6, imm12 = in_imm.
  - `ANDI: funct3 7, imm12 = in_imm.
  - `SLLI: funct3 1, imm12 = {7'h00, shamt}.
  - `SRLI: funct3 5, imm12 = {7'h00, shamt}.
  - `SRAI: funct3 5, imm12 = {7'h20, shamt}.
- Any other in_alu_control value is illegal. The request is still handshaken (consumed), but nothing is written to the FIFO, the counters do not change, and err_illegal pulses.
- Address counter addr_q: reset value BASE_ADDR. Each legal accepted request is written with addr_q, then addr_q advances by 4 modulo 2^ADDR_W. At the maximum address the counter wraps to 0, not to BASE_ADDR.
- FIFO: 2 entries of {instr, addr}, pointer-based, with count 0..2.
  - in_ready = !restart && (count < 2).
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - When count is 2 and a pop occurs, in_ready rises the next cycle (no same-cycle bypass).
- restart has priority over every handshake in the same cycle. The FIFO is cleared, addr_q returns to BASE_ADDR, emit_count returns to 0, any concurrent request is not accepted, and no pop is counted.
- rst has the same effect as restart and also clears err_illegal.
- Reset values: in_ready 1 after the reset cycle; out_valid 0; out_instr 0; out_addr 0; err_illegal 0; emit_count 0. An empty FIFO drives out_instr and out_addr to 0.

## Timing
- Latency: a request accepted on edge N appears at the FIFO head from cycle N+1 onward, provided the FIFO was empty.
- Throughput: one instruction per cycle while out_ready is held high.
- out_instr and out_addr are held stable while out_valid && !out_ready.
- err_illegal is registered; it is high for exactly the one cycle after the rejecting edge.
- emit_count updates on the accepting edge.

## Configuration
- ENC_SHAMT_CHECK_EN defined: a shift request with in_imm[11:5] != 0 is illegal (rejected, err_illegal pulses).
- ENC_SHAMT_CHECK_EN not defined: for shifts, in_imm[11:5] is ignored and shamt = in_imm[4:0]. No shift request is ever rejected for its immediate.

## Test plan
- `ADDI, rs1=1, rd=2, imm=12'h005, out_ready=1 -> out_instr 32'h00508113 at out_addr 0 one cycle later; emit_count 1.
- `SRAI, rs1=3, rd=4, imm=12'h003 -> 32'h4031D213; `SLLI, rs1=3, rd=4, imm=12'h003 -> 32'h00319213.
- out_ready=0, three back-to-back requests -> first two buffered, in_ready low after the second, third held. out_ready=1 -> the instructions drain in order at addresses 0, 4, 8.
- Illegal alu_control 5'h1F -> handshake completes, err_illegal pulses one cycle, FIFO count and address unchanged. `SLLI with imm=12'h020 -> rejected when ENC_SHAMT_CHECK_EN is defined; emits 32'h00019213 (rs1=3, rd=4) when it is not.
- ADDR_W=4, BASE_ADDR=4 -> four accepted requests get addresses 4, 8, 12, 0.
- restart asserted with 2 entries queued and in_valid high -> next cycle out_valid 0, emit_count 0, and the next accepted request gets BASE_ADDR.
